// File: rtl/nv_ram_rws_prm_if.sv
// nv_ram_rws_prm_if
//   Bundles the user-side signals of the nv_ram_rws_prm RAM model into one
//   port. The master side is the RAM user and the slave side is the RAM.
//
// Parameters
//   WIDTH : bits per data word
//   AW    : address width
//
// Signals (direction given from the master side)
//   clr           out  request to re-clear the whole array
//   ra            out  read address
//   re            out  read enable
//   dout          in   registered read data
//   dout_vld      in   dout was updated by the read accepted on the previous edge
//   wa            out  write address
//   we            out  write enable
//   di            out  write data
//   init_done     in   array is cleared and accepting reads and writes
//   pwrbus_ram_pd out  power-down bus; the RAM ignores it
interface nv_ram_rws_prm_if #(
  parameter int WIDTH = 10,
  parameter int AW    = 6
);
  logic             clr;
  logic [AW-1:0]    ra;
  logic             re;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    wa;
  logic             we;
  logic [WIDTH-1:0] di;
  logic             init_done;
  logic [31:0]      pwrbus_ram_pd;

  modport master (
    output clr, ra, re, wa, we, di, pwrbus_ram_pd,
    input  dout, dout_vld, init_done
  );

  modport slave (
    input  clr, ra, re, wa, we, di, pwrbus_ram_pd,
    output dout, dout_vld, init_done
  );
endinterface

// File: rtl/nv_ram_rws_prm.sv
// nv_ram_rws_prm
//   Parametrised single-clock RAM model with one read port and one write
//   port. The contents are swept to zero by an init state machine after
//   reset and whenever clr is sampled, so they are always deterministic.
//   Reads are registered, with a one-cycle valid strobe.
//
// Build option
//   NV_RAM_RWS_PRM_BYPASS_EN : when defined, a read and a write to the same
//   in-range address on the same edge return the new write data
//   (write-first). When undefined, the read returns the old contents
//   (read-first).
//
// Parameters
//   DEPTH : number of words (>= 2)
//   WIDTH : bits per word (>= 1)
//   AW    : address width (2**AW >= DEPTH)
//
// Ports
//   clk  in   clock; all logic runs on its rising edge
//   rstn in   asynchronous active-low reset
//   bus  slave modport of nv_ram_rws_prm_if (clr, ra/re/dout/dout_vld,
//        wa/we/di, init_done, pwrbus_ram_pd)
module nv_ram_rws_prm #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 10,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                rstn,
  nv_ram_rws_prm_if.slave     bus
);

  // One extra bit so that DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_nextCnt;
  logic             r_initDone;
  logic [WIDTH-1:0] r_dout;
  logic             r_doutVld;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_memWe;
  logic [AW-1:0]    w_memAddr;
  logic [WIDTH-1:0] w_memData;
  logic             w_rdAccept;
  logic             w_raOk;
  logic             w_waOk;

  // The power-down bus is accepted but has no effect on the model.
  logic             w_unused_pwrbus;
  assign w_unused_pwrbus = ^bus.pwrbus_ram_pd;

  assign w_raOk = ({1'b0, bus.ra} < DEPTH_EXT);
  assign w_waOk = ({1'b0, bus.wa} < DEPTH_EXT);

  // State, sweep counter and init_done. init_done tracks the next state
  // so it rises on the same edge as INIT->READY and falls on the clr edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= INIT;
      r_cnt      <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_initDone <= (w_nextState == READY);
    end
  end

  // Next state and the single memory write port. In INIT the port is
  // owned by the clearing sweep; in READY it serves user writes. clr wins
  // over any user access on the edge that samples it.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_memWe     = 1'b0;
    w_memAddr   = r_cnt;
    w_memData   = '0;
    w_rdAccept  = 1'b0;
    case (r_state)
      INIT: begin
        if (bus.clr) begin
          w_nextCnt = '0;
        end else begin
          w_memWe   = 1'b1;
          w_memAddr = r_cnt;
          w_memData = '0;
          // Stop at DEPTH-1 so a non-power-of-two depth never overruns.
          if (r_cnt == LAST_IDX) begin
            w_nextState = READY;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + AW'(1);
          end
        end
      end
      READY: begin
        if (bus.clr) begin
          w_nextState = INIT;
          w_nextCnt   = '0;
        end else begin
          if (bus.we && w_waOk) begin
            w_memWe   = 1'b1;
            w_memAddr = bus.wa;
            w_memData = bus.di;
          end
          w_rdAccept = bus.re;
        end
      end
      default: begin
        w_nextState = INIT;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Storage array; it is not reset because the sweep clears it.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  // Registered read. The array is read before this edge's write lands,
  // which gives read-first behaviour unless forwarding is built in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout    <= '0;
      r_doutVld <= 1'b0;
    end else begin
      r_doutVld <= w_rdAccept;
      if (w_rdAccept) begin
        if (!w_raOk) begin
          r_dout <= '0;
        end
`ifdef NV_RAM_RWS_PRM_BYPASS_EN
        else if (bus.we && (bus.wa == bus.ra)) begin
          r_dout <= bus.di;
        end
`endif
        else begin
          r_dout <= r_mem[bus.ra];
        end
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.dout_vld  = r_doutVld;
  assign bus.init_done = r_initDone;

endmodule

// File: tb/tb_nv_ram_rws_prm.sv
// tb_nv_ram_rws_prm
//   Directed bench for nv_ram_rws_prm. One instance has DEPTH=64 and
//   another has DEPTH=48 (non-power-of-two). Both share the clock and reset.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   that same point, which is after the edge has settled.
module tb_nv_ram_rws_prm;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  nv_ram_rws_prm_if #(.WIDTH(10), .AW(6)) b64 ();
  nv_ram_rws_prm_if #(.WIDTH(10), .AW(6)) b48 ();

  nv_ram_rws_prm #(.DEPTH(64), .WIDTH(10), .AW(6)) u64 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b64.slave)
  );

  nv_ram_rws_prm #(.DEPTH(48), .WIDTH(10), .AW(6)) u48 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b48.slave)
  );

  // Collision result depends on whether write-first forwarding is built in.
  localparam logic [9:0] COL_EXP =
`ifdef NV_RAM_RWS_PRM_BYPASS_EN
    10'h3FF;
`else
    10'h011;
`endif

  int checks = 0;
  int errors = 0;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the user inputs of one instance (sel48 = 0 -> DEPTH 64, 1 -> DEPTH 48).
  task automatic applyStimulus(input bit sel48, input logic clr, input logic we,
                               input logic [5:0] wa, input logic [9:0] di,
                               input logic re, input logic [5:0] ra);
    if (sel48) begin
      b48.clr = clr; b48.we = we; b48.wa = wa; b48.di = di; b48.re = re; b48.ra = ra;
    end else begin
      b64.clr = clr; b64.we = we; b64.wa = wa; b64.di = di; b64.re = re; b64.ra = ra;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b1;
    b64.pwrbus_ram_pd = 32'h0;
    b48.pwrbus_ram_pd = 32'hDEAD_BEEF;
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 0, 6'd0);
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 0, 6'd0);
    #1 rstn = 1'b0;
    tick();
    tick();

    // Reset values.
    checkOutput("rst_dout", b64.dout, 0);
    checkOutput("rst_vld", b64.dout_vld, 0);
    checkOutput("rst_init_done", b64.init_done, 0);
    checkOutput("rst_init_done48", b48.init_done, 0);

    // Release reset and count edges to init_done.
    rstn = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 47) checkOutput("init48_edge47", b48.init_done, 0);
      if (e == 48) checkOutput("init48_edge48", b48.init_done, 1);
      if (e == 63) checkOutput("init64_edge63", b64.init_done, 0);
      if (e == 64) checkOutput("init64_edge64", b64.init_done, 1);
    end

    // The whole array reads back zero after the sweep.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'(i));
      tick();
      checkOutput($sformatf("sweep_dout_%0d", i), b64.dout, 0);
      checkOutput($sformatf("sweep_vld_%0d", i), b64.dout_vld, 1);
    end

    // Basic write followed by a read.
    applyStimulus(0, 0, 1, 6'd5, 10'h2A5, 0, 6'd0);
    tick();
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd5);
    tick();
    checkOutput("basic_dout", b64.dout, 10'h2A5);
    checkOutput("basic_vld", b64.dout_vld, 1);
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 0, 6'd0);
    tick();
    checkOutput("basic_vld_drop", b64.dout_vld, 0);
    checkOutput("basic_hold1", b64.dout, 10'h2A5);
    tick();
    checkOutput("basic_hold2", b64.dout, 10'h2A5);

    // Same-address collision on addr 9.
    applyStimulus(0, 0, 1, 6'd9, 10'h011, 0, 6'd0);
    tick();
    applyStimulus(0, 0, 1, 6'd9, 10'h3FF, 1, 6'd9);
    tick();
    checkOutput("collision_dout", b64.dout, COL_EXP);
    checkOutput("collision_vld", b64.dout_vld, 1);
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd9);
    tick();
    checkOutput("collision_after", b64.dout, 10'h3FF);

    // Fill with nonzero data, then clear mid-operation.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1, 6'(i), 10'(i + 1), 0, 6'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd3);
    tick();
    checkOutput("fill_addr3", b64.dout, 10'h004);
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd63);
    tick();
    checkOutput("fill_addr63", b64.dout, 10'h040);
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd3);
    tick();
    applyStimulus(0, 1, 1, 6'd3, 10'h155, 1, 6'd3);
    tick();
    checkOutput("clr_init_done", b64.init_done, 0);
    checkOutput("clr_vld", b64.dout_vld, 0);
    checkOutput("clr_dout_hold", b64.dout, 10'h004);
    // Reads and writes during the sweep must be ignored.
    applyStimulus(0, 0, 1, 6'd10, 10'h3AA, 1, 6'd7);
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 1) checkOutput("clr_init_vld_e1", b64.dout_vld, 0);
      if (e == 63) begin
        checkOutput("clr_init_done_e63", b64.init_done, 0);
        checkOutput("clr_init_vld_e63", b64.dout_vld, 0);
      end
      if (e == 64) begin
        checkOutput("clr_init_done_e64", b64.init_done, 1);
        checkOutput("clr_init_vld_e64", b64.dout_vld, 0);
      end
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'(i));
      tick();
      checkOutput($sformatf("clr_read_dout_%0d", i), b64.dout, 0);
      checkOutput($sformatf("clr_read_vld_%0d", i), b64.dout_vld, 1);
    end

    // Non-power-of-two depth: out-of-range write dropped, read returns 0.
    applyStimulus(1, 0, 1, 6'd50, 10'h1FF, 0, 6'd0);
    tick();
    applyStimulus(1, 0, 1, 6'd47, 10'h123, 0, 6'd0);
    tick();
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 1, 6'd47);
    tick();
    checkOutput("d48_addr47", b48.dout, 10'h123);
    checkOutput("d48_addr47_vld", b48.dout_vld, 1);
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 1, 6'd50);
    tick();
    checkOutput("d48_addr50_dout", b48.dout, 0);
    checkOutput("d48_addr50_vld", b48.dout_vld, 1);
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 1, 6'd2);
    tick();
    checkOutput("d48_addr2", b48.dout, 0);
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 1, 6'd18);
    tick();
    checkOutput("d48_addr18", b48.dout, 0);
    applyStimulus(1, 0, 0, 6'd0, 10'd0, 0, 6'd0);

    // Asynchronous reset between edges while a read is active.
    applyStimulus(0, 0, 1, 6'd5, 10'h2A5, 0, 6'd0);
    tick();
    applyStimulus(0, 0, 0, 6'd0, 10'd0, 1, 6'd5);
    tick();
    checkOutput("pre_arst_dout", b64.dout, 10'h2A5);
    checkOutput("pre_arst_vld", b64.dout_vld, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_dout", b64.dout, 0);
    checkOutput("arst_vld", b64.dout_vld, 0);
    checkOutput("arst_init_done", b64.init_done, 0);
    checkOutput("arst_init_done48", b48.init_done, 0);
    #2 rstn = 1'b1;
    tick();
    checkOutput("post_arst_vld", b64.dout_vld, 0);
    checkOutput("post_arst_init_done", b64.init_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
